// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-RAM boot loader.
package imem_pkg;
  localparam int DEPTH_LOG2_DEF = 8;
  localparam int XLEN_DEF       = 32;
  localparam int LANE_W_DEF     = $clog2(XLEN_DEF / 8);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd2
  } state_e;

  typedef logic [LANE_W_DEF-1:0] lane_t;

  function automatic int lane_w(input int xlen);
    return (xlen > 8) ? $clog2(xlen / 8) : 1;
  endfunction
endpackage

// File: rtl/imem_word_packer.sv
// Assembles loader bytes little-endian into one instruction word; lanes not
// written since the last clear stay zero, which gives the padding for free.
module imem_word_packer
  import imem_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  input  logic            in_last,
  output logic [XLEN-1:0] word,
  output logic            word_ready,
  output logic            word_last
);
  localparam int LANES = XLEN / 8;
  localparam int LW    = lane_w(XLEN);

  logic [LW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            last_q, last_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    last_d     = last_q;
    word_ready = 1'b0;
    if (clr) begin
      byte_cnt_d = '0;
      buf_d      = '0;
      last_d     = 1'b0;
    end else if (in_valid) begin
      buf_d[{byte_cnt_q, 3'b000} +: 8] = in_byte;
      word_ready = (int'(byte_cnt_q) == LANES - 1) || in_last;
      byte_cnt_d = (int'(byte_cnt_q) == LANES - 1) ? '0 : byte_cnt_q + 1'b1;
      last_d     = in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      buf_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      last_q     <= last_d;
    end
  end

  assign word      = buf_q;
  assign word_last = last_q;
endmodule

// File: rtl/imem_boot_loader.sv
// Instruction RAM sequencer: byte-stream image load while the core stalls,
// then single-cycle-latency fetch access in RUN.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int XLEN       = XLEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  output logic                  ld_ready,
  input  logic                  reload,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic [XLEN-1:0]       fetch_rdata,
  output logic                  fetch_valid,
  output logic                  cpu_stall,
  output logic                  load_err,
  output logic [DEPTH_LOG2:0]   words_loaded,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata
);
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_e          state_q, state_d;
  logic            ld_ready_q, ld_ready_d;
  logic            cpu_stall_q, cpu_stall_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            load_err_q, load_err_d;
  logic [PW-1:0]   words_loaded_q, words_loaded_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic            accept, packer_clr;
  logic [XLEN-1:0] word;
  logic            word_ready, word_last;
  logic            unused_addr_bits;

  assign accept     = ld_valid && ld_ready_q && (state_q == LOAD);
  assign packer_clr = (state_q == WRITE) || ((state_q == RUN) && reload);
  assign unused_addr_bits = ^{fetch_addr[31:DEPTH_LOG2+2], fetch_addr[1:0]};

  imem_word_packer #(.XLEN(XLEN)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (packer_clr),
    .in_valid  (accept),
    .in_byte   (ld_byte),
    .in_last   (ld_last),
    .word      (word),
    .word_ready(word_ready),
    .word_last (word_last)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    words_loaded_d = words_loaded_q;
    load_err_d     = load_err_q;
    fetch_valid_d  = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = fetch_addr[DEPTH_LOG2+1:2];
    mem_wdata      = word;
    case (state_q)
      LOAD: if (word_ready) state_d = WRITE;
      WRITE: begin
        // Words past the end of the RAM are dropped and flagged, pointer holds.
        if (ptr_q < DEPTH) begin
          mem_en         = 1'b1;
          mem_we         = 1'b1;
          mem_addr       = ptr_q[DEPTH_LOG2-1:0];
          ptr_d          = ptr_q + 1'b1;
          words_loaded_d = ptr_q + 1'b1;
        end else begin
          load_err_d = 1'b1;
        end
        state_d = word_last ? RUN : LOAD;
      end
      RUN: begin
        if (reload) begin
          state_d        = LOAD;
          ptr_d          = '0;
          words_loaded_d = '0;
          load_err_d     = 1'b0;
        end else if (fetch_req) begin
          mem_en        = 1'b1;
          fetch_valid_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
    ld_ready_d  = (state_d == LOAD);
    cpu_stall_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= LOAD;
      ld_ready_q     <= 1'b1;
      cpu_stall_q    <= 1'b1;
      fetch_valid_q  <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= '0;
      ptr_q          <= '0;
    end else begin
      state_q        <= state_d;
      ld_ready_q     <= ld_ready_d;
      cpu_stall_q    <= cpu_stall_d;
      fetch_valid_q  <= fetch_valid_d;
      load_err_q     <= load_err_d;
      words_loaded_q <= words_loaded_d;
      ptr_q          <= ptr_d;
    end
  end

  assign ld_ready     = ld_ready_q;
  assign cpu_stall    = cpu_stall_q;
  assign fetch_valid  = fetch_valid_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;
  assign fetch_rdata  = mem_rdata;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench: expected RAM writes and fetch data are queued by the
// stimulus, and a negedge monitor pops and compares them.
module tb_imem_boot_loader;
  localparam int DL = 8;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, ld_last, ld_ready, reload, fetch_req;
  logic [7:0]    ld_byte;
  logic [31:0]   fetch_addr;
  logic [XL-1:0] fetch_rdata, mem_wdata, mem_rdata, ram_rd;
  logic          fetch_valid, cpu_stall, load_err, mem_en, mem_we;
  logic [DL:0]   words_loaded;
  logic [DL-1:0] mem_addr;

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH_LOG2(DL), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready), .reload(reload),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdata(fetch_rdata),
    .fetch_valid(fetch_valid), .cpu_stall(cpu_stall), .load_err(load_err),
    .words_loaded(words_loaded), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port synchronous RAM.
  logic [XL-1:0] ram [0:(1<<DL)-1];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rd <= ram[mem_addr];
    end
  assign mem_rdata = ram_rd;

  typedef struct { logic [DL-1:0] addr; logic [XL-1:0] data; } wr_t;
  wr_t           exp_wr[$];
  logic [XL-1:0] exp_rd[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    logic [XL-1:0] d;
    if (!rst && mem_en && mem_we) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h expected=none", mem_addr, mem_wdata);
      end else begin
        e = exp_wr.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          failures++;
          $display("FAIL ram_write actual=%0h:%0h expected=%0h:%0h", mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
    if (!rst && fetch_valid) begin
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL unexpected_fetch_valid data=%0h expected=none", fetch_rdata);
      end else begin
        d = exp_rd.pop_front();
        if (fetch_rdata !== d) begin
          failures++;
          $display("FAIL fetch_data actual=%0h expected=%0h", fetch_rdata, d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    while (!ld_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!ld_ready) begin
      checks++; failures++;
      $display("FAIL ld_ready_timeout actual=0 expected=1");
    end
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (cpu_stall && n < 20) begin @(posedge clk); #1; n++; end
    chk("wait_run_stall", cpu_stall, 0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  // Issues one fetch; caller drops fetch_req when the burst ends.
  task automatic do_fetch(input logic [31:0] a, input logic [DL-1:0] ea, input logic [XL-1:0] ed);
    fetch_req = 1'b1; fetch_addr = a;
    exp_rd.push_back(ed);
    #1;
    chk("fetch_mem_en", mem_en, 1);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_mem_addr", mem_addr, ea);
    @(posedge clk); #1;
    chk("fetch_valid_next", fetch_valid, 1);
  endtask

  function automatic logic [31:0] pat(input int w);
    logic [8:0] v;
    v = w[8:0];
    return {v[8:1], 8'h3C, ~v[7:0], v[7:0]};
  endfunction

  logic [7:0] img1 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pw;
    rst = 1'b1; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_words_loaded", words_loaded, 0);

    // Two-word image; stall drops the cycle after the second WRITE.
    exp_wr.push_back('{addr: 8'd0, data: 32'h0000_0013});
    exp_wr.push_back('{addr: 8'd1, data: 32'h0010_0093});
    for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
    chk("t1_stall_in_write", cpu_stall, 1);
    chk("t1_we_in_write", mem_we, 1);
    @(posedge clk); #1;
    chk("t1_stall_after_write", cpu_stall, 0);
    chk("t1_words_loaded", words_loaded, 2);

    // Back-to-back fetches, 0x400 wraps to word 0.
    do_fetch(32'h0, 8'd0, 32'h0000_0013);
    do_fetch(32'h4, 8'd1, 32'h0010_0093);
    do_fetch(32'h400, 8'd0, 32'h0000_0013);
    fetch_req = 1'b0;
    @(posedge clk); #1;
    chk("t3_valid_drop", fetch_valid, 0);

    // Overflow: 257 words, only 256 fit.
    do_reload();
    chk("t4_reload_stall", cpu_stall, 1);
    chk("t4_reload_words", words_loaded, 0);
    for (int w = 0; w < 257; w++) begin
      pw = pat(w);
      if (w < 256) exp_wr.push_back('{addr: w[7:0], data: pw});
      for (int k = 0; k < 4; k++) send_byte(pw[8*k +: 8], (w == 256) && (k == 3));
    end
    wait_run();
    chk("t4_load_err", load_err, 1);
    chk("t4_words_loaded", words_loaded, 256);
    chk("t4_writes_done", exp_wr.size(), 0);

    // reload beats a simultaneous fetch.
    fetch_req = 1'b1; fetch_addr = 32'h4; reload = 1'b1;
    #1;
    chk("t5_no_mem_en", mem_en, 0);
    @(posedge clk); #1;
    reload = 1'b0; fetch_req = 1'b0;
    chk("t5_fetch_valid", fetch_valid, 0);
    chk("t5_cpu_stall", cpu_stall, 1);
    chk("t5_load_err_clr", load_err, 0);
    chk("t5_words_clr", words_loaded, 0);
    chk("t5_ld_ready", ld_ready, 1);

    // Partial word is zero-padded and lands at address 0.
    exp_wr.push_back('{addr: 8'd0, data: 32'h00CC_BBAA});
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_run();
    chk("t2_words_loaded", words_loaded, 1);
    chk("t2_load_err", load_err, 0);
    do_fetch(32'h0, 8'd0, 32'h00CC_BBAA);
    do_fetch(32'h404, 8'd1, pat(1));
    fetch_req = 1'b0;

    // rst after two bytes discards them.
    @(posedge clk); #1;
    do_reload();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rst_words", words_loaded, 0);
    chk("t6_rst_ld_ready", ld_ready, 1);
    chk("t6_rst_stall", cpu_stall, 1);
    chk("t6_rst_mem_en", mem_en, 0);
    exp_wr.push_back('{addr: 8'd0, data: 32'h4433_2211});
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    wait_run();
    chk("t6_words_loaded", words_loaded, 1);
    do_fetch(32'h0, 8'd0, 32'h4433_2211);
    fetch_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("final_wr_queue_empty", exp_wr.size(), 0);
    chk("final_rd_queue_empty", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
